frv_axi_adapter_ot: RTL and testbench

FRV_AXI_ADAPTER_OT -- requirements
Module: frv_axi_adapter_ot

---
 rtl/frv_axi_pkg.sv | 29 ++
 rtl/frv_axi_ord_fifo.sv | 58 +++++
 rtl/frv_axi_adapter_ot.sv | 180 ++++++++++++++++++
 tb/tb_frv_axi_adapter_ot.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_axi_pkg.sv
// Shared constants for the FRV core-to-AXI4-lite adapter:
// AXI response codes, prot bit positions and order-entry types.
package frv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

    localparam logic ORD_RD = 1'b0;
    localparam logic ORD_WR = 1'b1;

    // Any non-OKAY code (EXOKAY included) is reported as an error.
    function automatic logic resp_err(input logic [1:0] r);
        return r != RESP_OKAY;
    endfunction

    function automatic logic [2:0] prot_f(input logic instr);
        logic [2:0] p;
        p = '0;
        p[PROT_INSTR] = instr;
        return p;
    endfunction

endpackage

// File: rtl/frv_axi_ord_fifo.sv
// Order FIFO: remembers the type of each granted request until answered.
// Ports: i_clk, i_rst (sync, high), i_push/i_data, i_pop, o_data (head),
//        o_full, o_empty, o_count (occupancy). DEPTH must be a power of two.
module frv_axi_ord_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 1,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/frv_axi_adapter_ot.sv
// Core memory port to AXI4-lite bridge with multiple outstanding requests,
// answered to the core strictly in request order.
// Ports: g_clk, g_reset (sync, high); mem_axi_aw/w/b/ar/r AXI4-lite master;
//        mem_req/wen/strb/wdata/addr/gnt core request; mem_recv/ack/error/
//        rdata core response; mem_outstanding order-FIFO occupancy.
// Macro FRV_AXI_ADAPTER_RSP_REG_EN: register the response (+1 cycle).
module frv_axi_adapter_ot
    import frv_axi_pkg::*;
#(
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 32,
    parameter  int OUTSTANDING     = 4,
    parameter  int INSTR_INTERFACE = 0,
    localparam int SW              = DATA_W / 8,
    localparam int CW              = $clog2(OUTSTANDING + 1)
) (
    input  logic              g_clk,
    input  logic              g_reset,
    output logic              mem_axi_awvalid,
    input  logic              mem_axi_awready,
    output logic [ADDR_W-1:0] mem_axi_awaddr,
    output logic [2:0]        mem_axi_awprot,
    output logic              mem_axi_wvalid,
    input  logic              mem_axi_wready,
    output logic [DATA_W-1:0] mem_axi_wdata,
    output logic [SW-1:0]     mem_axi_wstrb,
    input  logic              mem_axi_bvalid,
    output logic              mem_axi_bready,
    input  logic [1:0]        mem_axi_bresp,
    output logic              mem_axi_arvalid,
    input  logic              mem_axi_arready,
    output logic [ADDR_W-1:0] mem_axi_araddr,
    output logic [2:0]        mem_axi_arprot,
    input  logic              mem_axi_rvalid,
    output logic              mem_axi_rready,
    input  logic [DATA_W-1:0] mem_axi_rdata,
    input  logic [1:0]        mem_axi_rresp,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [SW-1:0]     mem_strb,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_gnt,
    output logic              mem_recv,
    input  logic              mem_ack,
    output logic              mem_error,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [CW-1:0]     mem_outstanding
);

    logic r_aw_done;
    logic r_w_done;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_head_wr;
    logic w_head_rd;
    logic w_wr_req;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_wr_gnt;
    logic w_rd_gnt;
    logic w_pop;

    assign mem_axi_awaddr = mem_addr;
    assign mem_axi_araddr = mem_addr;
    assign mem_axi_wdata  = mem_wdata;
    assign mem_axi_wstrb  = mem_strb;
    assign mem_axi_awprot = prot_f(INSTR_INTERFACE != 0);
    assign mem_axi_arprot = prot_f(INSTR_INTERFACE != 0);

    assign w_wr_req = !g_reset && mem_req && mem_wen && !w_full;

    assign mem_axi_arvalid = !g_reset && mem_req && !mem_wen && !w_full;
    assign mem_axi_awvalid = w_wr_req && !r_aw_done;
    assign mem_axi_wvalid  = w_wr_req && !r_w_done;

    assign w_aw_hs  = mem_axi_awvalid && mem_axi_awready;
    assign w_w_hs   = mem_axi_wvalid && mem_axi_wready;
    assign w_rd_gnt = mem_axi_arvalid && mem_axi_arready;
    // Each channel counts as done if it finished earlier or finishes now.
    assign w_wr_gnt = w_wr_req && (r_aw_done || w_aw_hs)
                               && (r_w_done || w_w_hs);
    assign mem_gnt  = w_wr_gnt || w_rd_gnt;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_wr_gnt) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end
    end

    frv_axi_ord_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_ord (
        .i_clk   (g_clk),
        .i_rst   (g_reset),
        .i_push  (mem_gnt),
        .i_data  (mem_wen),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (mem_outstanding)
    );

    assign w_head_wr = !w_empty && (w_head == ORD_WR);
    assign w_head_rd = !w_empty && (w_head == ORD_RD);
    assign w_pop     = mem_recv && mem_ack;

`ifdef FRV_AXI_ADAPTER_RSP_REG_EN
    logic              r_rsp_vld;
    logic              r_rsp_err;
    logic              r_rsp_wr;
    logic [DATA_W-1:0] r_rsp_data;
    logic              w_b_hs;
    logic              w_r_hs;

    assign w_b_hs = mem_axi_bvalid && mem_axi_bready;
    assign w_r_hs = mem_axi_rvalid && mem_axi_rready;

    // The head entry stays in the FIFO until the core takes the
    // registered copy; the empty-register condition stops a re-capture.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_wr   <= 1'b0;
            r_rsp_data <= '0;
        end else if (w_b_hs || w_r_hs) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_wr   <= w_b_hs;
            r_rsp_err  <= w_b_hs ? resp_err(mem_axi_bresp)
                                 : resp_err(mem_axi_rresp);
            r_rsp_data <= w_b_hs ? '0 : mem_axi_rdata;
        end else if (w_pop) begin
            r_rsp_vld  <= 1'b0;
        end
    end
`endif

    always_comb begin
        mem_recv       = 1'b0;
        mem_error      = 1'b0;
        mem_rdata      = '0;
        mem_axi_bready = 1'b0;
        mem_axi_rready = 1'b0;
`ifdef FRV_AXI_ADAPTER_RSP_REG_EN
        mem_axi_bready = w_head_wr && !r_rsp_vld;
        mem_axi_rready = w_head_rd && !r_rsp_vld;
        mem_recv       = r_rsp_vld;
        mem_error      = r_rsp_err;
        mem_rdata      = r_rsp_wr ? '0 : r_rsp_data;
`else
        if (w_head_wr) begin
            mem_recv       = mem_axi_bvalid;
            mem_axi_bready = mem_ack;
            mem_error      = resp_err(mem_axi_bresp);
        end else if (w_head_rd) begin
            mem_recv       = mem_axi_rvalid;
            mem_axi_rready = mem_ack;
            mem_error      = resp_err(mem_axi_rresp);
            mem_rdata      = mem_axi_rdata;
        end
`endif
        if (g_reset) begin
            mem_recv       = 1'b0;
            mem_axi_bready = 1'b0;
            mem_axi_rready = 1'b0;
        end
    end

endmodule

// File: tb/tb_frv_axi_adapter_ot.sv
// Bench for frv_axi_adapter_ot: directed scenarios, then random traffic
// against an in-order transaction model with a randomly stalling slave.
module tb_frv_axi_adapter_ot;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OT = 4;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(OT + 1);
`ifdef FRV_AXI_ADAPTER_RSP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          g_clk;
    logic          g_reset;
    logic          awvalid, awready, wvalid, wready;
    logic          bvalid, bready, arvalid, arready;
    logic          rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [DW-1:0] wdata, rdata_ax;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          req, wen, gnt, recv, ack, err;
    logic [SW-1:0] strb;
    logic [DW-1:0] cwdata, crdata;
    logic [AW-1:0] addr;
    logic [CW-1:0] outst;

    int n_checks = 0;
    int n_errs   = 0;

    frv_axi_adapter_ot dut (
        .g_clk           (g_clk),
        .g_reset         (g_reset),
        .mem_axi_awvalid (awvalid),
        .mem_axi_awready (awready),
        .mem_axi_awaddr  (awaddr),
        .mem_axi_awprot  (awprot),
        .mem_axi_wvalid  (wvalid),
        .mem_axi_wready  (wready),
        .mem_axi_wdata   (wdata),
        .mem_axi_wstrb   (wstrb),
        .mem_axi_bvalid  (bvalid),
        .mem_axi_bready  (bready),
        .mem_axi_bresp   (bresp),
        .mem_axi_arvalid (arvalid),
        .mem_axi_arready (arready),
        .mem_axi_araddr  (araddr),
        .mem_axi_arprot  (arprot),
        .mem_axi_rvalid  (rvalid),
        .mem_axi_rready  (rready),
        .mem_axi_rdata   (rdata_ax),
        .mem_axi_rresp   (rresp),
        .mem_req         (req),
        .mem_wen         (wen),
        .mem_strb        (strb),
        .mem_wdata       (cwdata),
        .mem_addr        (addr),
        .mem_gnt         (gnt),
        .mem_recv        (recv),
        .mem_ack         (ack),
        .mem_error       (err),
        .mem_rdata       (crdata),
        .mem_outstanding (outst)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        req = 0; wen = 0; strb = '0; cwdata = '0; addr = '0; ack = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata_ax = '0;
    endtask

    task automatic do_reset();
        idle();
        g_reset = 1;
        cyc();
        cyc();
        g_reset = 0;
    endtask

    // Hold the presented B/R until accepted; wait for the core response.
    task automatic wait_rsp(input string tag, input logic e_err,
                            input logic [DW-1:0] e_data, output int lat);
        bit got;
        bit hsr, hsb;
        got = 0;
        lat = -1;
        for (int i = 0; i < 12 && !got; i++) begin
            settle();
            if (recv === 1'b1) begin
                chk({tag, "_err"}, 64'(err), 64'(e_err));
                chk({tag, "_data"}, 64'(crdata), 64'(e_data));
                got = 1;
                lat = i;
            end
            hsr = rvalid && rready;
            hsb = bvalid && bready;
            cyc();
            if (hsr) rvalid = 0;
            if (hsb) bvalid = 0;
        end
        chk({tag, "_seen"}, 64'(got), 64'd1);
    endtask

    // ---------------- random-phase reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    r;
    } rsp_t;

    bit         ord_q[$];
    rsp_t       rd_exp[$];
    rsp_t       rd_slv[$];
    logic [1:0] wr_exp[$];
    logic [1:0] wr_slv[$];
    bit         aw_seen, w_seen;

    task automatic rnd_cycle(input bit gen_en);
        int   sz;
        bit   full, e_arv, e_awv, e_wv, e_gnt, b_hs, r_hs;
        rsp_t rr;
        logic [1:0] wb;
        settle();
        sz    = ord_q.size();
        full  = (sz == OT);
        e_arv = req && !wen && !full;
        e_awv = req && wen && !full && !aw_seen;
        e_wv  = req && wen && !full && !w_seen;
        if (wen)
            e_gnt = req && !full && (aw_seen || (e_awv && awready))
                                 && (w_seen || (e_wv && wready));
        else
            e_gnt = e_arv && arready;
        chk("rnd_outstanding", 64'(outst), 64'(sz));
        chk("rnd_arvalid", 64'(arvalid), 64'(e_arv));
        chk("rnd_awvalid", 64'(awvalid), 64'(e_awv));
        chk("rnd_wvalid", 64'(wvalid), 64'(e_wv));
        chk("rnd_gnt", 64'(gnt), 64'(e_gnt));
        chk("rnd_araddr", 64'(araddr), 64'(addr));
        chk("rnd_wdata", 64'(wdata), 64'(cwdata));
        chk("rnd_rready_head",
            64'(rready && !(sz > 0 && ord_q[0] == 1'b0)), 64'd0);
        chk("rnd_bready_head",
            64'(bready && !(sz > 0 && ord_q[0] == 1'b1)), 64'd0);
`ifndef FRV_AXI_ADAPTER_RSP_REG_EN
        chk("rnd_recv", 64'(recv),
            64'(sz > 0 && (ord_q[0] ? bvalid : rvalid)));
`endif
        if (recv && ack) begin
            chk("rnd_rsp_pending", 64'(sz > 0), 64'd1);
            if (sz > 0) begin
                if (ord_q[0]) begin
                    chk("rnd_wr_q", 64'(wr_exp.size() > 0), 64'd1);
                    if (wr_exp.size() > 0) begin
                        wb = wr_exp.pop_front();
                        chk("rnd_wr_err", 64'(err), 64'(wb != 2'b00));
                        chk("rnd_wr_data", 64'(crdata), 64'd0);
                    end
                end else begin
                    chk("rnd_rd_q", 64'(rd_exp.size() > 0), 64'd1);
                    if (rd_exp.size() > 0) begin
                        rr = rd_exp.pop_front();
                        chk("rnd_rd_err", 64'(err), 64'(rr.r != 2'b00));
                        chk("rnd_rd_data", 64'(crdata), 64'(rr.d));
                    end
                end
                void'(ord_q.pop_front());
            end
        end
        if (e_gnt) begin
            ord_q.push_back(wen);
            if (wen) begin
                wb = 2'($urandom);
                wr_exp.push_back(wb);
                wr_slv.push_back(wb);
                aw_seen = 0;
                w_seen  = 0;
            end else begin
                rr.d = $urandom;
                rr.r = 2'($urandom);
                rd_exp.push_back(rr);
                rd_slv.push_back(rr);
            end
        end else begin
            if (e_awv && awready) aw_seen = 1;
            if (e_wv && wready)   w_seen  = 1;
        end
        b_hs = bvalid && bready;
        r_hs = rvalid && rready;
        if (b_hs && wr_slv.size() > 0) void'(wr_slv.pop_front());
        if (r_hs && rd_slv.size() > 0) void'(rd_slv.pop_front());
        cyc();
        if (!req || e_gnt) begin
            if (gen_en && $urandom_range(0, 3) != 0) begin
                req    = 1;
                wen    = 1'($urandom);
                addr   = $urandom;
                cwdata = $urandom;
                strb   = SW'($urandom);
            end else begin
                req = 0;
            end
        end
        awready = 1'($urandom);
        wready  = 1'($urandom);
        arready = 1'($urandom);
        ack     = ($urandom_range(0, 3) != 0);
        if (!bvalid || b_hs) begin
            if (wr_slv.size() > 0 && $urandom_range(0, 1) == 1) begin
                bvalid = 1;
                bresp  = wr_slv[0];
            end else begin
                bvalid = 0;
            end
        end
        if (!rvalid || r_hs) begin
            if (rd_slv.size() > 0 && $urandom_range(0, 1) == 1) begin
                rvalid   = 1;
                rdata_ax = rd_slv[0].d;
                rresp    = rd_slv[0].r;
            end else begin
                rvalid = 0;
            end
        end
    endtask

    initial begin
        int lat;
        int guard;

        // Reset state with active-looking inputs
        idle();
        g_reset = 1;
        req = 1; arready = 1; rvalid = 1; bvalid = 1; ack = 1;
        cyc();
        settle();
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_recv", 64'(recv), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_outstanding", 64'(outst), 64'd0);
        wen = 1;
        settle();
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);

        // Single read
        do_reset();
        req = 1; wen = 0; addr = 32'h100; arready = 1;
        settle();
        chk("rd_arvalid", 64'(arvalid), 64'd1);
        chk("rd_gnt", 64'(gnt), 64'd1);
        chk("rd_araddr", 64'(araddr), 64'h100);
        chk("rd_arprot", 64'(arprot), 64'd0);
        cyc();
        req = 0; arready = 0;
        settle();
        chk("rd_outst1", 64'(outst), 64'd1);
        chk("rd_recv_early", 64'(recv), 64'd0);
        cyc();
        rvalid = 1; rdata_ax = 32'hDEADBEEF; rresp = 0; ack = 1;
        wait_rsp("rd_rsp", 1'b0, 32'hDEADBEEF, lat);
        chk("rd_latency", 64'(lat), 64'(LAT));
        settle();
        chk("rd_outst0", 64'(outst), 64'd0);

        // Write with W accepted three cycles before AW
        req = 1; wen = 1; addr = 32'h200; cwdata = 32'h11223344;
        strb = 4'hF; wready = 1; awready = 0;
        settle();
        chk("wr_awvalid", 64'(awvalid), 64'd1);
        chk("wr_wvalid", 64'(wvalid), 64'd1);
        chk("wr_gnt0", 64'(gnt), 64'd0);
        chk("wr_wdata", 64'(wdata), 64'h11223344);
        chk("wr_wstrb", 64'(wstrb), 64'hF);
        chk("wr_awprot", 64'(awprot), 64'd0);
        for (int i = 1; i < 3; i++) begin
            cyc();
            settle();
            chk("wr_no_rep_w", 64'(wvalid), 64'd0);
            chk("wr_wait_gnt", 64'(gnt), 64'd0);
            chk("wr_aw_hold", 64'(awvalid), 64'd1);
        end
        cyc();
        awready = 1;
        settle();
        chk("wr_gnt", 64'(gnt), 64'd1);
        chk("wr_awaddr", 64'(awaddr), 64'h200);
        chk("wr_w_quiet", 64'(wvalid), 64'd0);
        cyc();
        req = 0; awready = 0; wready = 0;
        settle();
        chk("wr_outst1", 64'(outst), 64'd1);
        chk("wr_aw_idle", 64'(awvalid), 64'd0);
        bvalid = 1; bresp = 2'b10; ack = 1;
        wait_rsp("wr_slverr", 1'b1, '0, lat);
        chk("wr_latency", 64'(lat), 64'(LAT));
        settle();
        chk("wr_outst0", 64'(outst), 64'd0);

        // Write then read; R arrives before B
        req = 1; wen = 1; addr = 32'h300; cwdata = 32'hA5;
        awready = 1; wready = 1;
        settle();
        chk("b2b_wr_gnt", 64'(gnt), 64'd1);
        cyc();
        wen = 0; addr = 32'h304; arready = 1; awready = 0; wready = 0;
        settle();
        chk("b2b_rd_gnt", 64'(gnt), 64'd1);
        cyc();
        req = 0; arready = 0;
        rvalid = 1; rdata_ax = 32'h5555AAAA; rresp = 0; ack = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("b2b_outst2", 64'(outst), 64'd2);
            chk("b2b_rready_stall", 64'(rready), 64'd0);
            chk("b2b_recv_stall", 64'(recv), 64'd0);
            cyc();
        end
        bvalid = 1; bresp = 0;
        wait_rsp("b2b_wr_first", 1'b0, '0, lat);
        wait_rsp("b2b_rd_second", 1'b0, 32'h5555AAAA, lat);
        settle();
        chk("b2b_outst0", 64'(outst), 64'd0);

        // Fill the order FIFO with reads
        req = 1; wen = 0; arready = 1; ack = 1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h400 + 32'(4 * i);
            settle();
            chk("ot_gnt", 64'(gnt), 64'd1);
            cyc();
        end
        addr = 32'h410;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("ot_full_arvalid", 64'(arvalid), 64'd0);
            chk("ot_full_gnt", 64'(gnt), 64'd0);
            chk("ot_full_outst", 64'(outst), 64'd4);
            cyc();
        end
        rvalid = 1; rdata_ax = 32'hCAFE0001; rresp = 2'b11;
        wait_rsp("ot_rresp3", 1'b1, 32'hCAFE0001, lat);
        settle();
        chk("ot_outst3", 64'(outst), 64'd3);
        chk("ot_5th_arvalid", 64'(arvalid), 64'd1);
        chk("ot_5th_gnt", 64'(gnt), 64'd1);
        cyc();

        // Reset with two reads in flight, then a late R
        do_reset();
        req = 1; wen = 0; arready = 1;
        cyc();
        cyc();
        req = 0; arready = 0;
        settle();
        chk("rr_outst2", 64'(outst), 64'd2);
        g_reset = 1; rvalid = 1; rdata_ax = 32'h77; ack = 1;
        settle();
        chk("rr_in_rst_rready", 64'(rready), 64'd0);
        chk("rr_in_rst_recv", 64'(recv), 64'd0);
        cyc();
        g_reset = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rr_late_rready", 64'(rready), 64'd0);
            chk("rr_late_recv", 64'(recv), 64'd0);
            chk("rr_outst0", 64'(outst), 64'd0);
            cyc();
        end

        // Random traffic, then drain
        do_reset();
        aw_seen = 0;
        w_seen  = 0;
        for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
        guard = 0;
        while ((ord_q.size() > 0 || req) && guard < 500) begin
            rnd_cycle(1'b0);
            guard++;
        end
        settle();
        chk("drain_done", 64'(guard < 500), 64'd1);
        chk("drain_outst", 64'(outst), 64'd0);
        chk("drain_rd_exp", 64'(rd_exp.size()), 64'd0);
        chk("drain_wr_exp", 64'(wr_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
